tcb_lib_arbiter: RTL and testbench
==================================

Name: tcb_lib_arbiter

Overview:
- Round-robin arbiter sharing one TCB subordinate port between MPN TCB manager ports.
- Accepts requests from MPN upstream managers on its sub-side ports and issues them on a single man-side port toward a shared memory or peripheral.
- Routes each response back to the originating manager exactly DLY cycles after the request handshake.
- Sits in front of register slices, passthroughs and memories in the TCB library.

Parameters:
- MPN, 2, number of manager ports sharing the subordinate (2..16).
- ABW, 32, address bus width.
- DBW, 32, data bus width.
- SLW, 8, selection width.
- BEW, DBW/SLW, byte enable width.
- DLY, 1, response delay in cycles (0..4); identical on both sides.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- sub_vld  input  MPN  per-manager request valid.
- sub_wen  input  MPN  per-manager write enable.
- sub_adr  input  MPN*ABW  per-manager address; port i at [i*ABW+:ABW].
- sub_ben  input  MPN*BEW  per-manager byte enable.
- sub_wdt  input  MPN*DBW  per-manager write data.
- sub_rdy  output  MPN  per-manager ready.
- sub_rdt  output  MPN*DBW  per-manager read data.
- sub_err  output  MPN  per-manager error response.
- man_vld  output  1  shared request valid.
- man_wen  output  1  shared write enable.
- man_adr  output  ABW  shared address.
- man_ben  output  BEW  shared byte enable.
- man_wdt  output  DBW  shared write data.
- man_rdy  input  1  shared ready.
- man_rdt  input  DBW  shared read data.
- man_err  input  1  shared error.

Behaviour:
- Handshake: a transfer occurs on any cycle with vld & rdy. Requests are presented combinationally in the same cycle, with no added request latency.
- Grant is combinational, one-hot or zero:
  - If the lock flag is set, grant = lock index.
  - Otherwise, grant goes to the first asserted sub_vld scanning from pointer ptr upward, wrapping at MPN-1 to 0.
  - No request asserted: grant = 0 and man_vld = 0.
- Request routing:
  - man_vld = |sub_vld.
  - man_wen/adr/ben/wdt = fields of the granted port; all zero when there is no grant.
  - sub_rdy[i] = man_rdy & grant[i]; non-granted ports see rdy = 0.
- Lock (stall hold):
  - Lock is set when man_vld & ~man_rdy. It stores the granted index and holds the grant stable until the transfer completes.
  - Lock is cleared on the transfer cycle.
  - A higher-priority request arriving during a stall is not served first.
- Pointer update:
  - On a transfer by port i, ptr <= (i+1) mod MPN, making i the lowest priority next cycle.
  - No transfer: ptr unchanged.
- Response routing:
  - A DLY-deep shift register carries {valid, index} of each transfer.
  - At stage DLY, sub_rdt[idx] = man_rdt and sub_err[idx] = man_err; all other ports output rdt = 0 and err = 0.
  - DLY = 0: routing uses the current-cycle grant combinationally.
  - Back-to-back transfers from different ports are supported every cycle; there is no turnaround bubble.
- Reset, asynchronous on rst low:
  - ptr = 0, lock = 0, index = 0, all pipeline stages invalid.
  - Outputs during reset follow the combinational rules above, so sub_rdy and man_vld track inputs. All sub_rdt/sub_err = 0.
  - Reset mid-transaction discards outstanding responses: no response is routed for transfers in flight at reset.
- Width rules:
  - Index width = $clog2(MPN).
  - Pointer wrap is an explicit compare with MPN-1, not a power-of-two wrap.

Decomposition:
- tcb_pkg:
  - Request struct typedef (wen, adr, ben, wdt) parameterized via localparams.
  - Response struct typedef (rdt, err).
  - MPN_MAX constant.
- Sub-module tcb_lib_arbiter_rr:
  - Round-robin priority selector: inputs req[MPN], ptr, lock, lock_idx; outputs one-hot grant and encoded index.
  - Purely combinational, reused by future multi-subordinate interconnects.
- tcb_lib_arbiter owns ptr, lock and the response pipeline.

Test Plan:
1. Single requester: sub_vld = 01, port 0 writes adr 0x10, wdt 0x01234567, man_rdy = 1. Expected: man_adr = 0x10 in the same cycle; sub_rdy = 01; a read of 0x10 returns sub_rdt[0] = 0x01234567 DLY cycles after its handshake; sub_rdt[1] = 0.
2. Contention fairness: MPN = 2, both ports assert vld continuously for 6 cycles from reset. Expected: grant sequence 0,1,0,1,0,1; each port completes 3 transfers.
3. Stall hold: port 1 granted with man_rdy = 0 for 3 cycles while port 0 raises vld in stall cycle 2. Expected: port 1 stays granted with man_adr stable; transfer happens when man_rdy = 1; port 0 is granted the next cycle.
4. Pointer wrap: MPN = 3, port 2 transfers, then ports 0 and 2 request. Expected: port 0 granted (ptr wrapped to 0).
5. Response interleave: DLY = 2, back-to-back reads by ports 0, 1, 0 returning 0xA, 0xB, 0xC with man_err = 0,1,0. Expected: sub_rdt[0] = 0xA, then sub_rdt[1] = 0xB with sub_err[1] = 1, then sub_rdt[0] = 0xC, each exactly 2 cycles after its handshake.
6. Reset mid-flight: DLY = 2, read handshake by port 1, then rst low for 1 cycle before the response. Expected: no sub_err/sub_rdt asserted for port 1; ptr = 0 after reset, so port 0 wins the next contention.

Source files
------------

// File: rtl/tcb_pkg.sv
// Shared TCB definitions: request/response field bundles and arbiter sizing helpers.
package tcb_pkg;

    localparam int unsigned MPN_MAX = 32'd16;
    localparam int unsigned TCB_ABW = 32'd32;
    localparam int unsigned TCB_DBW = 32'd32;
    localparam int unsigned TCB_SLW = 32'd8;
    localparam int unsigned TCB_BEW = TCB_DBW / TCB_SLW;

    typedef struct packed {
        logic               wen;
        logic [TCB_ABW-1:0] adr;
        logic [TCB_BEW-1:0] ben;
        logic [TCB_DBW-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DBW-1:0] rdt;
        logic               err;
    } tcb_rsp_t;

    // Manager index width; a single-manager build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/tcb_lib_arbiter_rr.sv
// Combinational round-robin selector: scans requests from ptr upward with wrap,
// or forces the locked index while a stalled request is being held.
module tcb_lib_arbiter_rr
    import tcb_pkg::*;
#(
    parameter  int unsigned MPN = 2,
    localparam int unsigned IW  = idx_width(MPN)
) (
    input  logic [MPN-1:0] req,
    input  logic [IW-1:0]  ptr,
    input  logic           lock,
    input  logic [IW-1:0]  lock_idx,
    output logic [MPN-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic          found_s;
    logic [IW-1:0] pos_s;

    // Priority scan starting at ptr; wrap is an explicit subtract of MPN.
    always_comb begin
        gnt     = {MPN{1'b0}};
        idx     = {IW{1'b0}};
        found_s = 1'b0;
        pos_s   = {IW{1'b0}};
        if (lock) begin
            gnt[lock_idx] = 1'b1;
            idx           = lock_idx;
        end else begin
            for (int unsigned k = 0; k < MPN; k++) begin
                if ((32'(ptr) + k) >= MPN) begin
                    pos_s = IW'(32'(ptr) + k - MPN);
                end else begin
                    pos_s = IW'(32'(ptr) + k);
                end
                if (!found_s && req[pos_s]) begin
                    found_s    = 1'b1;
                    gnt[pos_s] = 1'b1;
                    idx        = pos_s;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate between MPN managers; responses
// are steered back to the originating manager DLY cycles after the handshake.
module tcb_lib_arbiter
    import tcb_pkg::*;
#(
    parameter int unsigned MPN = 2,
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned SLW = 8,
    parameter int unsigned BEW = DBW / SLW,
    parameter int unsigned DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MPN-1:0]     sub_vld,
    input  logic [MPN-1:0]     sub_wen,
    input  logic [MPN*ABW-1:0] sub_adr,
    input  logic [MPN*BEW-1:0] sub_ben,
    input  logic [MPN*DBW-1:0] sub_wdt,
    output logic [MPN-1:0]     sub_rdy,
    output logic [MPN*DBW-1:0] sub_rdt,
    output logic [MPN-1:0]     sub_err,
    output logic               man_vld,
    output logic               man_wen,
    output logic [ABW-1:0]     man_adr,
    output logic [BEW-1:0]     man_ben,
    output logic [DBW-1:0]     man_wdt,
    input  logic               man_rdy,
    input  logic [DBW-1:0]     man_rdt,
    input  logic               man_err
);

    localparam int unsigned IW = idx_width(MPN);

    logic [MPN-1:0] gnt_s;
    logic [IW-1:0]  gnt_idx_s;
    logic           trn_s;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic           lock_q, lock_d;
    logic [IW-1:0]  lock_idx_q, lock_idx_d;
    logic           rsp_vld_s;
    logic [IW-1:0]  rsp_idx_s;

    tcb_lib_arbiter_rr #(
        .MPN (MPN)
    ) u_rr (
        .req      (sub_vld),
        .ptr      (ptr_q),
        .lock     (lock_q),
        .lock_idx (lock_idx_q),
        .gnt      (gnt_s),
        .idx      (gnt_idx_s)
    );

    // Request path: AND-OR mux of the granted port, zero when nothing is granted.
    always_comb begin
        man_vld = |sub_vld;
        man_wen = 1'b0;
        man_adr = {ABW{1'b0}};
        man_ben = {BEW{1'b0}};
        man_wdt = {DBW{1'b0}};
        for (int i = 0; i < MPN; i++) begin
            man_wen = man_wen | (sub_wen[i] & gnt_s[i]);
            man_adr = man_adr | (sub_adr[i*ABW +: ABW] & {ABW{gnt_s[i]}});
            man_ben = man_ben | (sub_ben[i*BEW +: BEW] & {BEW{gnt_s[i]}});
            man_wdt = man_wdt | (sub_wdt[i*DBW +: DBW] & {DBW{gnt_s[i]}});
        end
        sub_rdy = gnt_s & {MPN{man_rdy}};
        trn_s   = man_vld & man_rdy;
    end

    // Pointer advances past the served port; a stall freezes the grant until it completes.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (trn_s) begin
            ptr_d  = (gnt_idx_s == IW'(MPN - 32'd1)) ? {IW{1'b0}} : (gnt_idx_s + IW'(32'd1));
            lock_d = 1'b0;
        end else if (man_vld) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= {IW{1'b0}};
            lock_q     <= 1'b0;
            lock_idx_q <= {IW{1'b0}};
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    generate
        if (DLY == 0) begin : g_rsp_comb
            assign rsp_vld_s = trn_s;
            assign rsp_idx_s = gnt_idx_s;
        end else begin : g_rsp_pipe
            logic [DLY-1:0] pvld_q, pvld_d;
            logic [IW-1:0]  pidx_q [DLY];
            logic [IW-1:0]  pidx_d [DLY];

            // Shift {valid, index} of each handshake toward the response stage.
            always_comb begin
                pvld_d    = pvld_q;
                pidx_d    = pidx_q;
                pvld_d[0] = trn_s;
                pidx_d[0] = gnt_idx_s;
                for (int s = 1; s < DLY; s++) begin
                    pvld_d[s] = pvld_q[s-1];
                    pidx_d[s] = pidx_q[s-1];
                end
            end

            // Response pipeline registers; reset drops anything in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pvld_q <= {DLY{1'b0}};
                    for (int s = 0; s < DLY; s++) begin
                        pidx_q[s] <= {IW{1'b0}};
                    end
                end else begin
                    pvld_q <= pvld_d;
                    for (int s = 0; s < DLY; s++) begin
                        pidx_q[s] <= pidx_d[s];
                    end
                end
            end

            assign rsp_vld_s = pvld_q[DLY-1];
            assign rsp_idx_s = pidx_q[DLY-1];
        end
    endgenerate

    // Response demux: only the originating port sees rdt/err, all others read zero.
    always_comb begin
        sub_rdt = {(MPN*DBW){1'b0}};
        sub_err = {MPN{1'b0}};
        for (int i = 0; i < MPN; i++) begin
            sub_rdt[i*DBW +: DBW] = man_rdt & {DBW{rsp_vld_s & rst & (rsp_idx_s == IW'(i))}};
            sub_err[i]            = man_err & rsp_vld_s & rst & (rsp_idx_s == IW'(i));
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Scoreboard bench for tcb_lib_arbiter (MPN=3, DLY=2): directed stimulus pushes
// expected requests/responses; negedge monitors pop and compare.
module tb_tcb_lib_arbiter;

    localparam int MPN = 3;
    localparam int ABW = 32;
    localparam int DBW = 32;
    localparam int SLW = 8;
    localparam int BEW = 4;
    localparam int DLY = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [MPN-1:0]     sub_vld;
    logic [MPN-1:0]     sub_wen;
    logic [MPN*ABW-1:0] sub_adr;
    logic [MPN*BEW-1:0] sub_ben;
    logic [MPN*DBW-1:0] sub_wdt;
    logic [MPN-1:0]     sub_rdy;
    logic [MPN*DBW-1:0] sub_rdt;
    logic [MPN-1:0]     sub_err;
    logic               man_vld;
    logic               man_wen;
    logic [ABW-1:0]     man_adr;
    logic [BEW-1:0]     man_ben;
    logic [DBW-1:0]     man_wdt;
    logic               man_rdy;
    logic [DBW-1:0]     man_rdt;
    logic               man_err;

    always #5 clk = ~clk;

    tcb_lib_arbiter #(
        .MPN (MPN), .ABW (ABW), .DBW (DBW), .SLW (SLW), .BEW (BEW), .DLY (DLY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sub_vld (sub_vld),
        .sub_wen (sub_wen),
        .sub_adr (sub_adr),
        .sub_ben (sub_ben),
        .sub_wdt (sub_wdt),
        .sub_rdy (sub_rdy),
        .sub_rdt (sub_rdt),
        .sub_err (sub_err),
        .man_vld (man_vld),
        .man_wen (man_wen),
        .man_adr (man_adr),
        .man_ben (man_ben),
        .man_wdt (man_wdt),
        .man_rdy (man_rdy),
        .man_rdt (man_rdt),
        .man_err (man_err)
    );

    typedef struct packed {
        logic [MPN-1:0] rdy;
        logic           wen;
        logic [ABW-1:0] adr;
        logic [BEW-1:0] ben;
        logic [DBW-1:0] wdt;
    } req_t;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] sch_rdt [int];
    logic        sch_err [int];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    // Request monitor: every valid cycle must match the next expected request.
    always @(negedge clk) begin : mon_req
        req_t got;
        req_t exp;
        got = {sub_rdy, man_wen, man_adr, man_ben, man_wdt};
        checks++;
        if (man_vld) begin
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected cyc=%0d: got %h required no request", cyc, got);
            end else begin
                exp = req_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL req cyc=%0d: got %h required %h", cyc, got, exp);
                end
            end
        end else if (got !== '0) begin
            errors++;
            $display("FAIL idle_zero cyc=%0d: got %h required 0", cyc, got);
        end
    end

    // Response monitor: outputs must be zero except on a due cycle for the right port.
    always @(negedge clk) begin : mon_rsp
        logic [MPN*DBW-1:0] er;
        logic [MPN-1:0]     ee;
        rsp_t               r;
        er = '0;
        ee = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            er[r.port*DBW +: DBW] = r.rdt;
            ee[r.port]            = r.err;
        end
        checks++;
        if ({sub_rdt, sub_err} !== {er, ee}) begin
            errors++;
            $display("FAIL rsp cyc=%0d: got rdt=%h err=%b required rdt=%h err=%b",
                     cyc, sub_rdt, sub_err, er, ee);
        end
    end

    task automatic set_port(input int p, input logic wen, input logic [31:0] adr,
                            input logic [31:0] wdt);
        sub_wen[p]            = wen;
        sub_adr[p*ABW +: ABW] = adr;
        sub_wdt[p*DBW +: DBW] = wdt;
    endtask

    // One clock cycle; the subordinate returns garbage unless a response is scheduled.
    task automatic go(input logic [MPN-1:0] vld, input logic rdy);
        sub_vld = vld;
        man_rdy = rdy;
        if (sch_rdt.exists(cyc)) begin
            man_rdt = sch_rdt[cyc];
            man_err = sch_err[cyc];
        end else begin
            man_rdt = 32'hDEADBEEF;
            man_err = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic exp_req(input logic [MPN-1:0] rdy, input int p);
        req_t e;
        e = {rdy, sub_wen[p], sub_adr[p*ABW +: ABW], sub_ben[p*BEW +: BEW], sub_wdt[p*DBW +: DBW]};
        req_q.push_back(e);
    endtask

    task automatic exp_rsp(input int p, input logic [31:0] rdt, input logic err);
        rsp_t r;
        r.due  = cyc + DLY;
        r.port = p;
        r.rdt  = rdt;
        r.err  = err;
        rsp_q.push_back(r);
        sch_rdt[cyc + DLY] = rdt;
        sch_err[cyc + DLY] = err;
    endtask

    // Handshake this cycle by hand-chosen winner p, with its scheduled response.
    task automatic xfer(input int p, input logic [MPN-1:0] vld, input logic [31:0] rdt,
                        input logic err);
        logic [MPN-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        exp_req(oh, p);
        exp_rsp(p, rdt, err);
        go(vld, 1'b1);
    endtask

    task automatic stall(input int p, input logic [MPN-1:0] vld);
        exp_req(3'b000, p);
        go(vld, 1'b0);
    endtask

    initial begin
        rst     = 1'b0;
        sub_vld = '0;
        sub_wen = '0;
        sub_adr = '0;
        sub_ben = {4'hC, 4'h3, 4'hF};
        sub_wdt = '0;
        man_rdy = 1'b0;
        man_rdt = '0;
        man_err = 1'b0;
        set_port(0, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b0, 32'h24, 32'h11111111);
        set_port(2, 1'b1, 32'h30, 32'h22222222);

        // Reset: request path stays combinational, responses stay quiet
        go(3'b000, 1'b0);
        go(3'b000, 1'b0);
        stall(0, 3'b001);
        go(3'b000, 1'b0);
        rst = 1'b1;
        go(3'b000, 1'b0);

        // Single requester: write then read back 0x10
        set_port(0, 1'b1, 32'h10, 32'h01234567);
        xfer(0, 3'b001, 32'h0, 1'b0);
        set_port(0, 1'b0, 32'h10, 32'h0);
        xfer(0, 3'b001, 32'h01234567, 1'b0);
        for (int i = 0; i < 3; i++) go(3'b000, 1'b1);

        // Fresh reset, then 6 cycles of contention between ports 0 and 1
        rst = 1'b0;
        go(3'b000, 1'b0);
        rst = 1'b1;
        go(3'b000, 1'b0);
        set_port(0, 1'b0, 32'h20, 32'h0);
        set_port(1, 1'b0, 32'h24, 32'h0);
        for (int k = 0; k < 6; k++) xfer(k % 2, 3'b011, 32'h1000 + 32'(k), 1'b0);

        // Stall hold: port 1 keeps the grant while port 0 arrives mid-stall
        set_port(1, 1'b0, 32'h40, 32'h0);
        stall(1, 3'b010);
        stall(1, 3'b011);
        stall(1, 3'b011);
        xfer(1, 3'b011, 32'h0B1, 1'b0);
        xfer(0, 3'b001, 32'h0A0, 1'b0);

        // Pointer wrap: port 2 served, then port 0 wins over port 2
        xfer(2, 3'b100, 32'h0, 1'b1);
        xfer(0, 3'b101, 32'h0A1, 1'b0);

        // Interleaved responses 0,1,0
        xfer(0, 3'b001, 32'hA, 1'b0);
        xfer(1, 3'b010, 32'hB, 1'b1);
        xfer(0, 3'b001, 32'hC, 1'b0);
        for (int i = 0; i < 3; i++) go(3'b000, 1'b1);

        // Reset mid-flight: the port 1 read response must never appear
        exp_req(3'b010, 1);
        sch_rdt[cyc + DLY] = 32'h66;
        sch_err[cyc + DLY] = 1'b1;
        go(3'b010, 1'b1);
        rst = 1'b0;
        go(3'b000, 1'b0);
        rst = 1'b1;
        go(3'b000, 1'b0);
        xfer(0, 3'b111, 32'h77, 1'b0);
        xfer(1, 3'b110, 32'h78, 1'b0);
        for (int i = 0; i < 4; i++) go(3'b000, 1'b1);

        checks++;
        if (req_q.size() != 0) begin
            errors++;
            $display("FAIL req_drain: got %0d pending required 0", req_q.size());
        end
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_drain: got %0d pending required 0", rsp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
